vmodel_out_serializer: RTL and testbench
========================================

# vmodel_out_serializer

Downstream stage of the `vmodel` wrapper. It captures each 70-bit `model_out` word into a small FIFO and emits it as a valid/ready stream of 32-bit beats, least-significant beat first, with `m_last` on the final beat of each word. `vmodel` cannot be back-pressured, so the block reports dropped words through a sticky overflow flag and counts completed frames.

## Interface
- `IN_W`, 70: width of the captured model output word.
- `OUT_W`, 32: stream beat width.
- `DEPTH`, 2: capture FIFO depth in words; power of two, ≥2.
- `CNT_W`, 16: width of the frame counter.
- Derived `NBEATS` = ceil(IN_W/OUT_W) = 3 at defaults. `BEAT_W` = clog2(NBEATS).

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  a model output word is present this cycle.
- `in_data`  in  IN_W  model output word (`model_out`).
- `in_ready`  out  1  FIFO not full; a word is accepted on `in_valid && in_ready`.
- `m_valid`  out  1  beat valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_data`  out  OUT_W  beat payload.
- `m_last`  out  1  final beat of a word.
- `overflow`  out  1  sticky: a word was dropped.
- `frame_cnt`  out  CNT_W  completed words, wraps modulo 2^CNT_W.

## Operation
- **Reset values:** `m_valid`=0, `m_last`=0, `m_data`=0, `overflow`=0, `frame_cnt`=0. FIFO is empty, so `in_ready`=1. FSM is in IDLE. A mid-frame reset discards the partial frame and all queued words.
- **Push:** on `in_valid && in_ready`, `in_data` is written at the FIFO tail.
  - `in_ready` = !full, registered-state only. It has no combinational path from `m_ready`.
  - When full, a push in the same cycle as a pop is still refused.
- **Overflow:** `in_valid && !in_ready` drops the word and sets `overflow`. Only reset clears it.
- **FSM IDLE:** if the FIFO is non-empty, pop the head into a shift register, set beat=0, and go to SEND.
- **FSM SEND:**
  - `m_valid`=1.
  - `m_data` = word[OUT_W*beat +: OUT_W]. The final beat is zero-padded: bits 69:64 map to `m_data[5:0]` and the rest are 0.
  - `m_last` = (beat == NBEATS-1).
- **Beat handshake** (`m_valid && m_ready`):
  - Non-last beat: beat increments.
  - Last beat: `frame_cnt` increments. If the FIFO is non-empty, pop the next word and restart at beat 0 in SEND with no bubble; otherwise go to IDLE.
- **Stability:** while `m_valid && !m_ready`, `m_valid`, `m_data` and `m_last` hold stable. `m_valid` never drops without a handshake.

## Timing
- A word accepted at edge E presents beat 0 from edge E+1 when the FSM is idle. All stream outputs are registered.
- Sustained throughput is one beat per cycle, i.e. one word per NBEATS cycles. Input rate must not exceed that on average, or words are lost.
- Burst capacity without loss: DEPTH+1 words (FIFO plus shift register). At defaults, 3 consecutive words are absorbed and a 4th consecutive word is dropped.
- Reset assertion forces outputs to reset values immediately, without waiting for `clk`.

## Structure
- `vmodel_pkg` holds the shared constants: `VMODEL_IN_W`=60, `VMODEL_OUT_W`=70, `STREAM_W`=32, and the `NBEATS` ceil-div function. The matching upstream deserializer uses the same package.
- Sub-module `vmodel_sync_fifo` (DEPTH × IN_W):
  - Ports: push, pop, full, empty.
  - Pointers with an extra wrap bit.
  - Same async active-low reset.
- The top level contains the FSM, beat counter, shift register, overflow flag and frame counter.

## Test plan
- **Single word:** push 70'h2A_DEADBEEF_12345678 with `m_ready`=1 -> beats 32'h12345678, 32'hDEADBEEF, 32'h0000002A on consecutive cycles; `m_last` only on the third; `frame_cnt`=1.
- **Burst:** 4 words on consecutive cycles, `m_ready`=1 -> first 3 delivered as 9 gapless beats in order; 4th dropped; `overflow`=1 from the cycle after the drop; `frame_cnt`=3.
- **Backpressure:** single word, `m_ready` low for 5 cycles after beat 0 completes -> `m_data` holds 32'hDEADBEEF and `m_valid` stays 1 throughout; frame completes normally.
- **Reset mid-frame:** `rst_n`=0 during beat 1 with 1 word queued -> `m_valid`/`m_last`/`overflow`/`frame_cnt` reset to 0 asynchronously and `in_ready`=1. After release, a new word starts at beat 0 and the queued word never appears.
- **Randomised:** 1000 words at ≤1 per 4 cycles, `m_ready` 50% random -> scoreboard matches every beat; `overflow`=0; `frame_cnt`=1000.
- **Simultaneous events:** FIFO full while the last beat handshakes and `in_valid`=1 -> pop occurs; push refused; `overflow`=1; next frame follows with no bubble.

Source files
------------

// File: rtl/vmodel_pkg.sv
// Shared constants and helpers for the vmodel wrapper and its stream adapters.
package vmodel_pkg;

    localparam int VMODEL_IN_W  = 60;
    localparam int VMODEL_OUT_W = 70;
    localparam int STREAM_W     = 32;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

    // Number of stream beats needed to carry a word of word_w bits.
    function automatic int nbeats(input int word_w, input int beat_w);
        return (word_w + beat_w - 1) / beat_w;
    endfunction

endpackage

// File: rtl/vmodel_sync_fifo.sv
// Single-clock capture FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate count.
module vmodel_sync_fifo
    import vmodel_pkg::*;
#(
    parameter int WIDTH = VMODEL_OUT_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vmodel_out_serializer.sv
// Captures vmodel output words and streams them out LSB beat first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SER_IDLE | shift register empty, waiting for a word in the FIFO
// SER_SEND | presenting beats of the current word; m_valid asserted
module vmodel_out_serializer
    import vmodel_pkg::*;
#(
    parameter int IN_W  = VMODEL_OUT_W,
    parameter int OUT_W = STREAM_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int NBEATS = nbeats(IN_W, OUT_W);
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int PAD_W  = NBEATS * OUT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    ser_state_t        state_q;
    ser_state_t        state_d;
    logic [PAD_W-1:0]  shift_q;
    logic [BEAT_W-1:0] beat_q;
    logic              last_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  frame_cnt_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [IN_W-1:0]   fifo_rdata;
    logic              fifo_push;
    logic              fifo_pop;
    logic              beat_hs;

    // in_ready depends on FIFO pointer state only, never on m_ready.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;

    vmodel_sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: leave SEND only when the last beat goes and nothing is queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SER_IDLE: if (!fifo_empty) state_d = SER_SEND;
            SER_SEND: if (beat_hs && last_q && fifo_empty) state_d = SER_IDLE;
            default:  state_d = SER_IDLE;
        endcase
    end

    // FSM outputs: valid is a direct state decode; pop on idle or back-to-back reload.
    always_comb begin
        m_valid  = (state_q == SER_SEND);
        beat_hs  = (state_q == SER_SEND) && m_ready;
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state_q == SER_IDLE) begin
                fifo_pop = 1'b1;
            end else if (beat_hs && last_q) begin
                fifo_pop = 1'b1;
            end
        end
    end

    // Shift register and beat counter; the low OUT_W bits are always the current beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            beat_q  <= '0;
            last_q  <= 1'b0;
        end else if (fifo_pop) begin
            shift_q <= PAD_W'(fifo_rdata);
            beat_q  <= '0;
            last_q  <= (NBEATS == 1);
        end else if (beat_hs && !last_q) begin
            shift_q <= shift_q >> OUT_W;
            beat_q  <= beat_q + BEAT_W'(1);
            last_q  <= ((beat_q + BEAT_W'(1)) == LAST_BEAT);
        end else if (beat_hs) begin
            last_q  <= 1'b0;
        end
    end

    // Sticky overflow on a dropped word and completed-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (in_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end
            if (beat_hs && last_q) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

    assign m_data    = shift_q[OUT_W-1:0];
    assign m_last    = last_q;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vmodel_out_serializer.sv
// Scoreboard bench for vmodel_out_serializer: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_vmodel_out_serializer;

    localparam logic [69:0] W_A  = 70'h2A_DEADBEEF_12345678;
    localparam logic [69:0] W_B0 = 70'h01_11111111_A0000001;
    localparam logic [69:0] W_B1 = 70'h02_22222222_B0000002;
    localparam logic [69:0] W_B2 = 70'h03_33333333_C0000003;
    localparam logic [69:0] W_B3 = 70'h3F_44444444_D0000004;
    localparam logic [69:0] W_R0 = 70'h15_CAFEF00D_0BADBEEF;
    localparam logic [69:0] W_R1 = 70'h2B_FEEDFACE_55AA55AA;
    localparam logic [69:0] W_R2 = 70'h07_13579BDF_2468ACE0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [69:0] in_data;
    logic        in_ready;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        overflow;
    logic [15:0] frame_cnt;

    beat_t       exp_q[$];
    beat_t       mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          rand_en  = 1'b0;
    bit          stall_q  = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;

    always #5 clk = ~clk;

    vmodel_out_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] beat_of(input logic [69:0] w, input int i);
        logic [95:0] p;
        p = {26'b0, w};
        return p[32*i +: 32];
    endfunction

    task automatic push_exp(input logic [69:0] w);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{data: beat_of(w, i), last: (i == 2)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_en) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare each accepted beat and check stability across stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 96'(m_valid), 96'(1'b1));
                check("hold_data",  96'(m_data),  96'(stall_data));
                check("hold_last",  96'(m_last),  96'(stall_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat (t=%0t)",
                             m_data, m_last, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", 96'(m_data), 96'(mon_e.data));
                    check("beat_last", 96'(m_last), 96'(mon_e.last));
                end
            end
            stall_q    = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [95:0] rnd;
        int          waited;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        m_ready  = 1'b0;
        #2;
        check("rst_m_valid",   96'(m_valid),   96'(1'b0));
        check("rst_m_last",    96'(m_last),    96'(1'b0));
        check("rst_m_data",    96'(m_data),    96'(32'h0));
        check("rst_overflow",  96'(overflow),  96'(1'b0));
        check("rst_frame_cnt", 96'(frame_cnt), 96'(16'd0));
        check("rst_in_ready",  96'(in_ready),  96'(1'b1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word, hand-split beats.
        m_ready  = 1'b1;
        in_valid = 1'b1;
        in_data  = W_A;
        exp_q.push_back('{data: 32'h12345678, last: 1'b0});
        exp_q.push_back('{data: 32'hDEADBEEF, last: 1'b0});
        exp_q.push_back('{data: 32'h0000002A, last: 1'b1});
        step();
        in_valid = 1'b0;
        check("single_not_yet_valid", 96'(m_valid), 96'(1'b0));
        step();
        check("single_beat0_valid", 96'(m_valid), 96'(1'b1));
        check("single_beat0_data",  96'(m_data),  96'(32'h12345678));
        repeat (3) step();
        check("single_frame_cnt", 96'(frame_cnt), 96'(16'd1));
        check("single_idle",      96'(m_valid),   96'(1'b0));
        check("single_drained",   96'(exp_q.size()), 96'(0));

        // Backpressure after beat 0.
        in_valid = 1'b1;
        in_data  = W_A;
        push_exp(W_A);
        step();
        in_valid = 1'b0;
        step();
        step();
        m_ready = 1'b0;
        check("bp_beat1_data", 96'(m_data), 96'(32'hDEADBEEF));
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 96'(m_valid), 96'(1'b1));
            check("bp_data",  96'(m_data),  96'(32'hDEADBEEF));
            check("bp_last",  96'(m_last),  96'(1'b0));
        end
        m_ready = 1'b1;
        repeat (2) step();
        check("bp_frame_cnt", 96'(frame_cnt), 96'(16'd2));
        check("bp_idle",      96'(m_valid),   96'(1'b0));
        check("bp_drained",   96'(exp_q.size()), 96'(0));

        // Burst of four: three absorbed, fourth dropped.
        do_reset();
        m_ready  = 1'b1;
        in_valid = 1'b1;
        in_data  = W_B0;
        push_exp(W_B0);
        step();
        in_data = W_B1;
        push_exp(W_B1);
        step();
        in_data = W_B2;
        push_exp(W_B2);
        step();
        in_data = W_B3;
        check("burst_full",        96'(in_ready), 96'(1'b0));
        check("burst_no_overflow", 96'(overflow), 96'(1'b0));
        step();
        in_valid = 1'b0;
        check("burst_overflow", 96'(overflow), 96'(1'b1));
        repeat (6) step();
        check("burst_frames_mid", 96'(frame_cnt), 96'(16'd2));
        step();
        check("burst_frames_end", 96'(frame_cnt), 96'(16'd3));
        check("burst_idle",       96'(m_valid),   96'(1'b0));
        check("burst_drained",    96'(exp_q.size()), 96'(0));

        // Reset during beat 1 with another word queued.
        in_valid = 1'b1;
        in_data  = W_R0;
        push_exp(W_R0);
        step();
        in_data = W_R1;
        push_exp(W_R1);
        step();
        in_valid = 1'b0;
        step();
        check("rmid_beat1", 96'(m_data), 96'(beat_of(W_R0, 1)));
        rst_n = 1'b0;
        #1;
        check("rmid_m_valid",   96'(m_valid),   96'(1'b0));
        check("rmid_m_last",    96'(m_last),    96'(1'b0));
        check("rmid_overflow",  96'(overflow),  96'(1'b0));
        check("rmid_frame_cnt", 96'(frame_cnt), 96'(16'd0));
        check("rmid_in_ready",  96'(in_ready),  96'(1'b1));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = W_R2;
        push_exp(W_R2);
        step();
        in_valid = 1'b0;
        step();
        check("rmid_new_beat0", 96'(m_data), 96'(beat_of(W_R2, 0)));
        repeat (3) step();
        check("rmid_frame_cnt_after", 96'(frame_cnt), 96'(16'd1));
        check("rmid_idle",            96'(m_valid),   96'(1'b0));
        check("rmid_drained",         96'(exp_q.size()), 96'(0));

        // Full FIFO while the last beat handshakes and a word arrives.
        do_reset();
        m_ready  = 1'b1;
        in_valid = 1'b1;
        in_data  = W_B0;
        push_exp(W_B0);
        step();
        in_data = W_B1;
        push_exp(W_B1);
        step();
        in_data = W_B2;
        push_exp(W_B2);
        step();
        in_valid = 1'b0;
        check("sim_full", 96'(in_ready), 96'(1'b0));
        step();
        in_valid = 1'b1;
        in_data  = W_B3;
        check("sim_no_overflow_yet", 96'(overflow), 96'(1'b0));
        step();
        in_valid = 1'b0;
        check("sim_overflow",     96'(overflow), 96'(1'b1));
        check("sim_no_bubble",    96'(m_valid),  96'(1'b1));
        check("sim_next_beat0",   96'(m_data),   96'(beat_of(W_B1, 0)));
        check("sim_next_notlast", 96'(m_last),   96'(1'b0));
        check("sim_in_ready",     96'(in_ready), 96'(1'b1));
        repeat (6) step();
        check("sim_frame_cnt", 96'(frame_cnt), 96'(16'd3));
        check("sim_idle",      96'(m_valid),   96'(1'b0));
        check("sim_drained",   96'(exp_q.size()), 96'(0));

        // Randomised: 1000 words spaced at least 4 cycles, random m_ready.
        do_reset();
        rand_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(3, 6)) step();
            waited = 0;
            while (exp_q.size() > 3 && waited < 1000) begin
                step();
                waited++;
            end
            if (waited >= 1000) begin
                check("rand_drain_timeout", 96'(exp_q.size()), 96'(3));
                break;
            end
            rnd      = {$urandom, $urandom, $urandom};
            in_data  = rnd[69:0];
            in_valid = 1'b1;
            push_exp(rnd[69:0]);
            step();
            in_valid = 1'b0;
        end
        waited = 0;
        while ((exp_q.size() > 0 || m_valid) && waited < 2000) begin
            step();
            waited++;
        end
        rand_en = 1'b0;
        m_ready = 1'b1;
        check("rand_overflow",  96'(overflow),  96'(1'b0));
        check("rand_frame_cnt", 96'(frame_cnt), 96'(16'd1000));
        check("rand_drained",   96'(exp_q.size()), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
